// File: rtl/csd2bin_serial.sv
// Digit-serial signed-digit to two's complement converter, G digits per cycle, LSB first.
// Define CSD2BIN_CANON_CHK_EN to add the out_noncanon canonical-form flag.
module csd2bin_serial #(
  parameter int N = 8,
  parameter int G = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N:0]     out_s
`ifdef CSD2BIN_CANON_CHK_EN
  ,
  output logic           out_noncanon
`endif
);

  localparam int CHUNKS = N / G;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  n_q, n_d;
  logic [N-1:0]  res_q, res_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  p_in, n_in;
  logic [G:0]    diff;
  logic          load;

`ifdef CSD2BIN_CANON_CHK_EN
  logic nc_q, nc_d;
  logic prev_nz_q, prev_nz_d;
  logic chunk_bad, walk_nz, digit_nz;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      p_in[i] = in_d[2*i+1];
      n_in[i] = in_d[2*i];
    end

    // Chunk subtract; the extra top bit of diff is the outgoing borrow.
    diff = {1'b0, p_q[G-1:0]} - {1'b0, n_q[G-1:0]} - {{G{1'b0}}, borrow_q};

    state_d   = state_q;
    p_d       = p_q;
    n_d       = n_q;
    res_d     = res_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;

`ifdef CSD2BIN_CANON_CHK_EN
    nc_d      = nc_q;
    prev_nz_d = prev_nz_q;
    chunk_bad = 1'b0;
    walk_nz   = prev_nz_q;
    digit_nz  = 1'b0;
    for (int j = 0; j < G; j++) begin
      digit_nz = p_q[j] ^ n_q[j];
      if ((p_q[j] & n_q[j]) || (digit_nz & walk_nz)) chunk_bad = 1'b1;
      walk_nz = digit_nz;
    end
`endif

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) load = 1'b1;
      end
      CONV: begin
        p_d      = p_q >> G;
        n_d      = n_q >> G;
        res_d    = N'({diff[G-1:0], res_q} >> G);
        borrow_d = diff[G];
        cnt_d    = cnt_q + CW'(1);
`ifdef CSD2BIN_CANON_CHK_EN
        nc_d      = nc_q | chunk_bad;
        prev_nz_d = walk_nz;
`endif
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      p_d      = p_in;
      n_d      = n_in;
      res_d    = '0;
      borrow_d = 1'b0;
      cnt_d    = '0;
      state_d  = CONV;
`ifdef CSD2BIN_CANON_CHK_EN
      nc_d      = 1'b0;
      prev_nz_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      n_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef CSD2BIN_CANON_CHK_EN
      nc_q      <= 1'b0;
      prev_nz_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      n_q      <= n_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef CSD2BIN_CANON_CHK_EN
      nc_q      <= nc_d;
      prev_nz_q <= prev_nz_d;
`endif
    end
  end

  // The final borrow is the sign bit of the N+1-bit result.
  assign out_s = {borrow_q, res_q};
`ifdef CSD2BIN_CANON_CHK_EN
  assign out_noncanon = nc_q;
`endif

endmodule

// File: tb/tb_csd2bin_serial.sv
// Scoreboard testbench for csd2bin_serial (N=8, G=2) with directed, hand-computed vectors.
module tb_csd2bin_serial;

  localparam int N = 8;
  localparam int G = 2;
  localparam int LAT = N / G;

  typedef struct packed {
    logic [N:0] s;
    logic       nc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] in_d = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N:0]     out_s;
`ifdef CSD2BIN_CANON_CHK_EN
  logic           out_noncanon;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t exp_q[$];
  int   acc_q[$];

  csd2bin_serial #(.N(N), .G(G)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_d(in_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s(out_s)
`ifdef CSD2BIN_CANON_CHK_EN
    ,
    .out_noncanon(out_noncanon)
`endif
  );

  // Free-running clock and cycle counter used for latency measurement
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*N-1:0] pack(input logic [N-1:0] p, input logic [N-1:0] nv);
    logic [2*N-1:0] d;
    for (int i = 0; i < N; i++) begin
      d[2*i+1] = p[i];
      d[2*i]   = nv[i];
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Offer one operand, wait (bounded) for acceptance, then queue its expected result
  task automatic applyStimulus(input logic [N-1:0] p, input logic [N-1:0] nv,
                               input logic [N:0] exp_s, input logic exp_nc);
    int n;
    exp_t e;
    in_d     = pack(p, nv);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.s  = exp_s;
    e.nc = exp_nc;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  // Monitor: checks latency when out_valid rises and pops the scoreboard on each output handshake
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          checkOutput("unexpected_output", 32'd1, 32'd0);
        end else begin
          a = acc_q.pop_front();
          checkOutput("latency", cyc - a, LAT);
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("out_s", 32'(out_s), 32'(e.s));
`ifdef CSD2BIN_CANON_CHK_EN
        checkOutput("out_noncanon", 32'(out_noncanon), 32'(e.nc));
`endif
      end
    end
    prev_valid <= out_valid;
  end

  // Main directed sequence
  initial begin
    int   n;
    exp_t e;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_s", 32'(out_s), 32'd0);
    rst = 1'b0;

    applyStimulus(8'h05, 8'h00, 9'h005, 1'b0);
    applyStimulus(8'h00, 8'h01, 9'h1FF, 1'b0);
    applyStimulus(8'h00, 8'hFF, 9'h101, 1'b1);
    applyStimulus(8'hFF, 8'h00, 9'h0FF, 1'b1);
    applyStimulus(8'hAA, 8'hAA, 9'h000, 1'b1);
    applyStimulus(8'h80, 8'h02, 9'h07E, 1'b0);
    waitDrain();

    // Backpressure in DONE, then release together with a new operand
    out_ready = 1'b0;
    applyStimulus(8'h21, 8'h04, 9'h01D, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_out_s", 32'(out_s), 32'h01D);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_d      = pack(8'h00, 8'h50);
    #1;
    checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    e.s  = 9'h1B0;
    e.nc = 1'b0;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    checkOutput("b2b_valid_drop", 32'(out_valid), 32'd0);
    waitDrain();

    // Reset during the second conversion cycle discards the operand
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_d     = pack(8'h77, 8'h11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_s", 32'(out_s), 32'd0);
    applyStimulus(8'h03, 8'h01, 9'h002, 1'b1);
    waitDrain();

    // Input activity while converting must be ignored
    applyStimulus(8'h40, 8'h01, 9'h03F, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      in_valid = 1'b1;
      in_d     = 16'($urandom);
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    waitDrain();

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
